softmax_norm: RTL and testbench

Frame-level normalizer that sits directly downstream of the exp stage in the digital compute datapath and completes softmax. It captures each frame of unsigned exp values, accumulates their sum, then emits each value divided by the frame sum as an unsigned fixed-point fraction with `FRAC_BITS` fractional bits. Upstream has no backpressure, so the block ping-pong buffers two frames and drops whole frames when both buffers are busy.

---
 rtl/softmax_norm.sv | 227 ++++++++++++++++++++++
 tb/tb_softmax_norm.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_norm.sv
// softmax_norm: completes softmax by dividing each exp value of a frame by the frame sum.
// Two ping-pong frame buffers fill from the stream while a serial restoring divider drains the oldest.
module softmax_norm #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_LEN    = 12,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_tdata,
  input  logic                  input_tvalid,
  input  logic                  input_tlast,
  output logic [DATA_WIDTH-1:0] output_tdata,
  output logic                  output_tvalid,
  output logic                  output_tlast,
  output logic                  overflow
);
  localparam int CW = $clog2(MEM_LEN + 1);
  localparam int SW = DATA_WIDTH + CW;
  localparam int IW = (MEM_LEN > 1) ? $clog2(MEM_LEN) : 1;
  localparam int QW = FRAC_BITS + 1;
  localparam int BW = $clog2(QW + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MEM_LEN);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAC_BITS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_EMIT} state_t;

  logic [DATA_WIDTH-1:0] mem [2][MEM_LEN];
  logic [CW-1:0]         cnt [2];
  logic [SW-1:0]         sum [2];
  logic [1:0]            full;

  logic       in_frame, dropping, fill_sel, last_claim;
  logic       first_beat, pref, claim_ok, claim_sel, wr_sel, wr_en, room;
  logic [1:0] free_b, rel;
  logic [IW-1:0] wr_idx;

  logic [1:0] q_id;
  logic [1:0] q_cnt;
  logic       head, q_push;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [BW-1:0] bit_cnt;
  logic          load_en, step_en, emit_now, buf_release, last_elem, div_done, sum_zero;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [SW-1:0] div_rem;
  logic [QW-1:0] div_num, div_q, div_q_nxt;
  logic [SW:0]   step_r;

  // One restoring-division step: returns {quotient bit, new remainder}.
  function automatic logic [SW:0] div_step(input logic [SW-1:0] rem, input logic nb,
                                           input logic [SW-1:0] dvsr);
    logic [SW:0] trial;
    trial = {rem, nb};
    if (trial >= {1'b0, dvsr}) return {1'b1, SW'(trial - {1'b0, dvsr})};
    return {1'b0, trial[SW-1:0]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fmt_result(input logic [QW-1:0] q, input logic zero_sum);
    return zero_sum ? '0 : DATA_WIDTH'(q);
  endfunction

  // Fill side: a released buffer counts as free in the same cycle it is released.
  always_comb begin
    for (int b = 0; b < 2; b++) free_b[b] = !full[b] || rel[b];
    pref       = ~last_claim;
    first_beat = input_tvalid && !in_frame;
    claim_ok   = free_b[pref] || free_b[~pref];
    claim_sel  = free_b[pref] ? pref : ~pref;
    wr_sel     = first_beat ? claim_sel : fill_sel;
    wr_en      = input_tvalid && (first_beat ? claim_ok : !dropping);
    room       = first_beat || (cnt[fill_sel] < CNT_MAX);
    wr_idx     = first_beat ? '0 : IW'(cnt[fill_sel]);
    q_push     = wr_en && input_tlast;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_frame   <= 1'b0;
      dropping   <= 1'b0;
      fill_sel   <= 1'b0;
      last_claim <= 1'b1;
      overflow   <= 1'b0;
    end else if (input_tvalid) begin
      if (first_beat) begin
        fill_sel <= claim_sel;
        dropping <= !claim_ok;
        if (claim_ok) last_claim <= claim_sel;
        else          overflow   <= 1'b1;
      end else if (!dropping && !room) begin
        overflow <= 1'b1;
      end
      in_frame <= !input_tlast;
    end
  end

  // Fill writes come after the release so a same-cycle claim wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= '0;
      for (int b = 0; b < 2; b++) begin
        cnt[b] <= '0;
        sum[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (rel[b]) begin
          full[b] <= 1'b0;
          cnt[b]  <= '0;
          sum[b]  <= '0;
        end
        if (wr_en && (int'(wr_sel) == b)) begin
          if (first_beat) begin
            cnt[b] <= CW'(1);
            sum[b] <= SW'(input_tdata);
          end else if (room) begin
            cnt[b] <= cnt[b] + CW'(1);
            sum[b] <= sum[b] + SW'(input_tdata);
          end
          if (input_tlast) full[b] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && room) mem[wr_sel][wr_idx] <= input_tdata;
  end

  // Drain order queue: q_id[0] is the oldest closed frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_id  <= '0;
      q_cnt <= '0;
    end else begin
      case ({q_push, buf_release})
        2'b10: begin
          q_id[q_cnt[0]] <= wr_sel;
          q_cnt          <= q_cnt + 2'd1;
        end
        2'b01: begin
          q_id[0] <= q_id[1];
          q_cnt   <= q_cnt - 2'd1;
        end
        2'b11: begin
          if (q_cnt == 2'd2) begin
            q_id[0] <= q_id[1];
            q_id[1] <= wr_sel;
          end else begin
            q_id[0] <= wr_sel;
          end
        end
        default: ;
      endcase
    end
  end

  assign head      = q_id[0];
  assign rd_val    = mem[head][idx];
  assign last_elem = (CW'(idx) + CW'(1)) == cnt[head];
  assign div_done  = (bit_cnt == BIT_LAST);
  assign sum_zero  = (sum[head] == '0);
  assign step_r    = div_step(div_rem, div_num[QW-1], sum[head]);
  assign div_q_nxt = (div_q << 1) | QW'(step_r[SW]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (q_cnt != 2'd0) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_DIV;
      S_DIV:   if (div_done) state_nxt = S_EMIT;
      S_EMIT:  state_nxt = last_elem ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_en     = (state == S_LOAD);
    step_en     = (state == S_DIV);
    emit_now    = step_en && div_done;
    buf_release = (state == S_EMIT) && last_elem;
    rel         = buf_release ? (head ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      bit_cnt <= '0;
    end else begin
      if (load_en)      bit_cnt <= '0;
      else if (step_en) bit_cnt <= bit_cnt + BW'(1);
      if (state == S_EMIT) idx <= last_elem ? '0 : idx + IW'(1);
    end
  end

  // Quotient < 2^(FRAC_BITS+1), so the top bits of value<<FRAC_BITS seed the remainder.
  always_ff @(posedge clk) begin
    if (load_en) begin
      div_rem <= SW'(rd_val >> 1);
      div_num <= {rd_val[0], {FRAC_BITS{1'b0}}};
      div_q   <= '0;
    end else if (step_en) begin
      div_rem <= step_r[SW-1:0];
      div_num <= div_num << 1;
      div_q   <= div_q_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_tdata  <= '0;
      output_tvalid <= 1'b0;
      output_tlast  <= 1'b0;
    end else begin
      output_tvalid <= emit_now;
      output_tlast  <= emit_now && last_elem;
      if (emit_now) output_tdata <= fmt_result(div_q_nxt, sum_zero);
    end
  end

endmodule

// File: tb/tb_softmax_norm.sv
// tb_softmax_norm: directed and randomized frames checked against an arithmetic model of
// value*2^FRAC_BITS/sum, including drop, truncation, release-bypass and reset behaviour.
module tb_softmax_norm;
  localparam int DW = 16;
  localparam int ML = 12;
  localparam int FB = 8;
  localparam int SPACING = FB + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] input_tdata;
  logic          input_tvalid, input_tlast;
  logic [DW-1:0] output_tdata;
  logic          output_tvalid, output_tlast, overflow;

  softmax_norm #(.DATA_WIDTH(DW), .MEM_LEN(ML), .FRAC_BITS(FB)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_tdata  (input_tdata),
    .input_tvalid (input_tvalid),
    .input_tlast  (input_tlast),
    .output_tdata (output_tdata),
    .output_tvalid(output_tvalid),
    .output_tlast (output_tlast),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;
  int got_d[$];
  int got_l[$];
  int got_c[$];
  int exp_d[$];
  int exp_l[$];
  int fbuf[16];
  bit ovf_model;

  always @(negedge clk) begin
    if (rst === 1'b1 && output_tvalid === 1'b1) begin
      got_d.push_back(int'(output_tdata));
      got_l.push_back(int'(output_tlast));
      got_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_q(input int v, input longint s);
    if (s == 0) return 0;
    return int'((longint'(v) << FB) / s);
  endfunction

  task automatic clear_q();
    got_d.delete(); got_l.delete(); got_c.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  task automatic expect_frame(input int len);
    int n;
    longint s;
    n = (len > ML) ? ML : len;
    s = 0;
    for (int k = 0; k < n; k++) s += fbuf[k];
    for (int k = 0; k < n; k++) begin
      exp_d.push_back(ref_q(fbuf[k], s));
      exp_l.push_back((k == n - 1) ? 1 : 0);
    end
  endtask

  task automatic send_frame(input int len, input bit first_now, output int last_edge);
    last_edge = 0;
    for (int i = 0; i < len; i++) begin
      if (!(first_now && i == 0)) begin
        @(posedge clk);
        #1;
      end
      input_tdata  = DW'(fbuf[i]);
      input_tvalid = 1'b1;
      input_tlast  = (i == len - 1);
      if (i == len - 1) last_edge = cyc + 1;
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    input_tvalid = 1'b0;
    input_tlast  = 1'b0;
    input_tdata  = '0;
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int t;
    t = 0;
    while (got_d.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (got_d.size() < n) check("timeout", got_d.size(), n);
  endtask

  task automatic compare_all(input string tag);
    check({tag, " count"}, got_d.size(), exp_d.size());
    for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
      check({tag, " data"}, got_d[k], exp_d[k]);
      check({tag, " last"}, got_l[k], exp_l[k]);
    end
    clear_q();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_q();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int le, n, mode, len;
    bit seen;
    rst = 1'b0;
    input_tdata = '0;
    input_tvalid = 1'b0;
    input_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst tdata", output_tdata, 0);
    check("rst tvalid", output_tvalid, 0);
    check("rst tlast", output_tlast, 0);
    check("rst overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b1;

    // Basic frame with latency and spacing
    fbuf[0] = 1; fbuf[1] = 3; fbuf[2] = 7;
    send_frame(3, 1'b0, le);
    idle();
    expect_frame(3);
    wait_outputs(3, 200);
    for (int k = 0; k < got_c.size() && k < 3; k++)
      check("t1 timing", got_c[k], le + SPACING * (k + 1));
    repeat (20) @(negedge clk);
    compare_all("t1");
    check("t1 overflow", overflow, 0);

    fbuf[0] = 148;
    send_frame(1, 1'b0, le);
    idle();
    expect_frame(1);
    wait_outputs(1, 100);
    repeat (20) @(negedge clk);
    compare_all("single");

    fbuf[0] = 0; fbuf[1] = 0;
    send_frame(2, 1'b0, le);
    idle();
    expect_frame(2);
    wait_outputs(2, 100);
    repeat (20) @(negedge clk);
    compare_all("zero");

    // Three back-to-back full frames: the third is dropped
    reset_dut();
    for (int i = 0; i < ML; i++) fbuf[i] = 1;
    for (int f = 0; f < 3; f++) send_frame(ML, 1'b0, le);
    idle();
    expect_frame(ML);
    expect_frame(ML);
    wait_outputs(2 * ML, 400);
    repeat (200) @(negedge clk);
    compare_all("drop3");
    check("drop3 overflow", overflow, 1);

    // Release-bypass: frame 3 first beat sampled at the release edge
    reset_dut();
    for (int i = 0; i < ML; i++) fbuf[i] = 1;
    send_frame(ML, 1'b0, le);
    expect_frame(ML);
    for (int i = 0; i < ML; i++) fbuf[i] = 5;
    send_frame(ML, 1'b0, le);
    expect_frame(ML);
    idle();
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (output_tvalid === 1'b1 && output_tlast === 1'b1) seen = 1'b1;
    end
    check("bypass seen", seen, 1);
    fbuf[0] = 1; fbuf[1] = 3; fbuf[2] = 7;
    send_frame(3, 1'b1, le);
    idle();
    expect_frame(3);
    wait_outputs(2 * ML + 3, 600);
    repeat (20) @(negedge clk);
    compare_all("bypass");
    check("bypass overflow", overflow, 0);

    // Oversized frame truncated to MEM_LEN
    reset_dut();
    for (int i = 0; i < 14; i++) fbuf[i] = 2;
    send_frame(14, 1'b0, le);
    idle();
    expect_frame(14);
    wait_outputs(ML, 300);
    repeat (20) @(negedge clk);
    compare_all("long");
    check("long overflow", overflow, 1);

    // Asynchronous reset mid-division with a second frame queued
    fbuf[0] = 1; fbuf[1] = 3; fbuf[2] = 7;
    send_frame(3, 1'b0, le);
    fbuf[0] = 2; fbuf[1] = 2;
    send_frame(2, 1'b0, le);
    idle();
    wait_outputs(1, 100);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst tdata", output_tdata, 0);
    check("arst tvalid", output_tvalid, 0);
    check("arst tlast", output_tlast, 0);
    check("arst overflow", overflow, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_q();
    repeat (300) @(negedge clk);
    check("arst stale", got_d.size(), 0);
    fbuf[0] = 1; fbuf[1] = 3; fbuf[2] = 7;
    send_frame(3, 1'b0, le);
    idle();
    expect_frame(3);
    wait_outputs(3, 200);
    repeat (20) @(negedge clk);
    compare_all("arst frame");

    // Randomized frames, one at a time
    reset_dut();
    ovf_model = 1'b0;
    for (int it = 0; it < 12; it++) begin
      len  = $urandom_range(1, 14);
      mode = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) begin
        case (mode)
          0:       fbuf[i] = 0;
          1:       fbuf[i] = $urandom_range(0, 15);
          2:       fbuf[i] = $urandom_range(0, 65535);
          default: fbuf[i] = $urandom_range(65000, 65535);
        endcase
      end
      send_frame(len, 1'b0, le);
      idle();
      expect_frame(len);
      if (len > ML) ovf_model = 1'b1;
      n = (len > ML) ? ML : len;
      wait_outputs(n, 300);
      repeat (5) @(negedge clk);
      compare_all("rnd");
      check("rnd overflow", overflow, ovf_model);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
